// File: rtl/booth_multi_pkg.sv
// booth_multi_pkg -- shared types and helpers for the sequential Booth multiplier.
//
// Contents:
//   state_e        : controller states (IDLE, RUN, DONE)
//   booth_digit_t  : Booth digit code (sign + one-times / two-times magnitude)
//   RSTEP, WIN_W   : multiplier bits consumed per step and recoder window width
//   booth_iter()   : number of Booth steps for a given operand width
//
// Build option: BOOTH_MULTI_RADIX4_EN selects radix-4 recoding (digits -2..+2,
// WIDTH/2 steps). Left undefined, the multiplier is radix-2 (digits -1..+1,
// WIDTH steps). The product is the same in both builds.
package booth_multi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Digit value = (neg ? -1 : +1) * (two ? 2 : one ? 1 : 0)
  typedef struct packed {
    logic neg;
    logic two;
    logic one;
  } booth_digit_t;

`ifdef BOOTH_MULTI_RADIX4_EN
  localparam int RSTEP = 2;
`else
  localparam int RSTEP = 1;
`endif

  // Window = RSTEP fresh multiplier bits plus the bit just below them.
  localparam int WIN_W = RSTEP + 1;

  function automatic int booth_iter(input int width);
    return width / RSTEP;
  endfunction

endpackage

// File: rtl/booth_recoder.sv
// booth_recoder -- combinational Booth digit selection.
//
// Ports:
//   win   : multiplier bit window {b[i+RSTEP-1] .. b[i], b[i-1]}
//   digit : Booth digit code for that window
//
// Build option: BOOTH_MULTI_RADIX4_EN selects the 3-bit radix-4 table;
// otherwise the 2-bit radix-2 table is used.
module booth_recoder
  import booth_multi_pkg::*;
(
  input  logic [WIN_W-1:0] win,
  output booth_digit_t     digit
);

  always_comb begin
    digit = '0;
`ifdef BOOTH_MULTI_RADIX4_EN
    case (win)
      3'b001, 3'b010: digit.one = 1'b1;
      3'b011:         digit.two = 1'b1;
      3'b100: begin
        digit.two = 1'b1;
        digit.neg = 1'b1;
      end
      3'b101, 3'b110: begin
        digit.one = 1'b1;
        digit.neg = 1'b1;
      end
      default: ;
    endcase
`else
    case (win)
      2'b01: digit.one = 1'b1;
      2'b10: begin
        digit.one = 1'b1;
        digit.neg = 1'b1;
      end
      default: ;
    endcase
`endif
  end

endmodule

// File: rtl/booth_multi.sv
// booth_multi -- sequential Booth multiplier, one Booth step per clock.
//
// Ports:
//   clock       : rising-edge clock
//   reset       : asynchronous active-high reset
//   start       : request on a rising transition only (low last cycle, high now)
//   signed_mode : 1 = two's-complement operands, 0 = unsigned (sampled with request)
//   mlier       : multiplier (sampled with request)
//   mcand       : multiplicand (sampled with request)
//   prodt       : registered 2*WIDTH-bit product, held until the next valid
//   valid       : one-cycle pulse when prodt is updated
//   busy        : high while an operation is running
//
// Build option: BOOTH_MULTI_RADIX4_EN selects radix-4 recoding (WIDTH/2 steps)
// instead of radix-2 (WIDTH steps).
//
// Arithmetic: the multiplicand is extended to WIDTH+1 bits (sign or zero) and
// kept in a 2*WIDTH+2 bit left-shifting register. The recoder walks the WIDTH-bit
// multiplier as a signed number; for an unsigned multiplier with its MSB set the
// missing 2^WIDTH * mcand term is added on the last step.
module booth_multi
  import booth_multi_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   mlier,
  input  logic [WIDTH-1:0]   mcand,
  output logic [2*WIDTH-1:0] prodt,
  output logic               valid,
  output logic               busy
);

  localparam int ITER  = booth_iter(WIDTH);
  localparam int CNT_W = $clog2(ITER + 1);
  localparam int ACC_W = 2 * WIDTH + 2;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

  // Control state (reset)
  state_e               state_q, state_d;
  logic                 start_prev_q, start_prev_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   prodt_q, prodt_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;

  // Datapath state (not reset; always loaded on capture before use)
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] mcand_sh_q, mcand_sh_d;
  logic [WIDTH-1:0]        mlier_sh_q, mlier_sh_d;
  logic                    mprev_q, mprev_d;
  logic                    corr_q, corr_d;

  logic                    req;
  logic                    mcand_ext_bit;
  logic signed [ACC_W-1:0] mcand_ext;
  logic [WIN_W-1:0]        win;
  booth_digit_t            digit;
  logic signed [ACC_W-1:0] pp;
  logic signed [ACC_W-1:0] acc_sum;
  logic [2*WIDTH-1:0]      corr_add;

  assign req           = start & ~start_prev_q;
  assign mcand_ext_bit = signed_mode & mcand[WIDTH-1];
  assign mcand_ext     = $signed({{(ACC_W - WIDTH){mcand_ext_bit}}, mcand});
  assign win           = {mlier_sh_q[WIN_W-2:0], mprev_q};

  booth_recoder u_recoder (
    .win   (win),
    .digit (digit)
  );

  // Partial product: digit times the multiplicand already aligned to this step.
  always_comb begin
    pp = '0;
    if (digit.two) begin
      pp = mcand_sh_q <<< 1;
    end else if (digit.one) begin
      pp = mcand_sh_q;
    end
    if (digit.neg) begin
      pp = -pp;
    end
  end

  assign acc_sum = acc_q + pp;

  // On the last step mcand_sh_q sits at 2^(WIDTH-RSTEP); one more shift is 2^WIDTH.
  assign corr_add = corr_q ? {mcand_sh_q[2*WIDTH-1-RSTEP:0], {RSTEP{1'b0}}} : '0;

  always_comb begin
    state_d      = state_q;
    start_prev_d = start;
    cnt_d        = cnt_q;
    prodt_d      = prodt_q;
    valid_d      = 1'b0;
    acc_d        = acc_q;
    mcand_sh_d   = mcand_sh_q;
    mlier_sh_d   = mlier_sh_q;
    mprev_d      = mprev_q;
    corr_d       = corr_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (req) begin
          state_d    = ST_RUN;
          cnt_d      = '0;
          acc_d      = '0;
          mcand_sh_d = mcand_ext;
          mlier_sh_d = mlier;
          mprev_d    = 1'b0;
          corr_d     = ~signed_mode & mlier[WIDTH-1];
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_d      = acc_sum;
        mcand_sh_d = mcand_sh_q <<< RSTEP;
        mlier_sh_d = mlier_sh_q >> RSTEP;
        mprev_d    = mlier_sh_q[RSTEP-1];
        cnt_d      = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          prodt_d = acc_sum[2*WIDTH-1:0] + corr_add;
          valid_d = 1'b1;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_RUN);
  end

  // Control registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      start_prev_q <= 1'b0;
      cnt_q        <= '0;
      prodt_q      <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_prev_d;
      cnt_q        <= cnt_d;
      prodt_q      <= prodt_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clock) begin
    acc_q      <= acc_d;
    mcand_sh_q <= mcand_sh_d;
    mlier_sh_q <= mlier_sh_d;
    mprev_q    <= mprev_d;
    corr_q     <= corr_d;
  end

  assign prodt = prodt_q;
  assign valid = valid_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_booth_multi.sv
// tb_booth_multi -- scoreboard bench for booth_multi at WIDTH=32 and WIDTH=8.
// Expected products come from plain integer multiplication of the
// (sign- or zero-extended) operands.
module tb_booth_multi;

`ifdef BOOTH_MULTI_RADIX4_EN
  localparam int ITER32 = 16;
`else
  localparam int ITER32 = 32;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  logic        start32 = 1'b0, sm32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic [63:0] prodt32;
  logic        valid32, busy32;

  logic        start8 = 1'b0, sm8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] prodt8;
  logic        valid8, busy8;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] exp_q32[$];
  logic [15:0] exp_q8[$];

  always #5 clock = ~clock;

  booth_multi #(.WIDTH(32)) dut32 (
    .clock(clock), .reset(reset), .start(start32), .signed_mode(sm32),
    .mlier(a32), .mcand(b32), .prodt(prodt32), .valid(valid32), .busy(busy32)
  );

  booth_multi #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .start(start8), .signed_mode(sm8),
    .mlier(a8), .mcand(b8), .prodt(prodt8), .valid(valid8), .busy(busy8)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref32(input logic sm, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = sm ? longint'($signed(a)) : longint'({32'b0, a});
    sb = sm ? longint'($signed(b)) : longint'({32'b0, b});
    return 64'(sa * sb);
  endfunction

  function automatic logic [15:0] ref8(input logic sm, input logic [7:0] a, input logic [7:0] b);
    int sa, sb;
    sa = sm ? int'($signed(a)) : int'({24'b0, a});
    sb = sm ? int'($signed(b)) : int'({24'b0, b});
    return 16'(sa * sb);
  endfunction

  function automatic logic [31:0] rnd32();
    int unsigned k;
    k = $urandom_range(0, 9);
    case (k)
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h0;
      3: return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  // Monitors: pop one expectation per valid pulse.
  always @(negedge clock) begin
    if (valid32) begin
      chk("busy_in_done32", {63'b0, busy32}, 64'd0);
      if (exp_q32.size() == 0) chk("spurious_valid32", 64'd1, 64'd0);
      else chk("prod32", prodt32, exp_q32.pop_front());
    end
    if (valid8) begin
      if (exp_q8.size() == 0) chk("spurious_valid8", 64'd1, 64'd0);
      else chk("prod8", {48'b0, prodt8}, {48'b0, exp_q8.pop_front()});
    end
  end

  // Caller is at a negedge; the request is captured on the next posedge.
  task automatic issue32(input logic sm, input logic [31:0] a, input logic [31:0] b);
    start32 = 1'b1; sm32 = sm; a32 = a; b32 = b;
    exp_q32.push_back(ref32(sm, a, b));
    @(negedge clock);
    start32 = 1'b0;
  endtask

  // Returns the number of edges after capture at which valid was seen (0 = timeout).
  task automatic wait_v32(output int n);
    n = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clock);
      if (valid32) begin
        n = i;
        break;
      end
    end
    if (n == 0) chk("timeout32", 64'd0, 64'd1);
  endtask

  task automatic wait_v8();
    int n;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      if (valid8) begin
        n = i;
        break;
      end
    end
    if (n == 0) chk("timeout8", 64'd0, 64'd1);
  endtask

  initial begin
    int n;
    int pulses;
    logic [63:0] prev;

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_prodt", prodt32, 64'd0);
    chk("rst_valid", {63'b0, valid32}, 64'd0);
    chk("rst_busy", {63'b0, busy32}, 64'd0);
    reset = 1'b0;
    @(negedge clock);

    // 3 x -5 signed, latency and busy
    issue32(1'b1, 32'h0000_0003, 32'hFFFF_FFFB);
    chk("busy_run", {63'b0, busy32}, 64'd1);
    wait_v32(n);
    chk("latency", 64'(n), 64'(ITER32));
    chk("prod_3x-5", prodt32, 64'hFFFF_FFFF_FFFF_FFF1);

    issue32(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_v32(n);
    chk("prod_umax", prodt32, 64'hFFFF_FFFE_0000_0001);
    issue32(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_v32(n);
    chk("prod_sm1", prodt32, 64'h0000_0000_0000_0001);
    issue32(1'b1, 32'h8000_0000, 32'h8000_0000);
    wait_v32(n);
    chk("prod_smin", prodt32, 64'h4000_0000_0000_0000);
    repeat (2) @(negedge clock);

    // Start held high for 40 cycles: one pulse only
    start32 = 1'b1; sm32 = 1'b0; a32 = 32'd1234; b32 = 32'd5678;
    exp_q32.push_back(ref32(1'b0, 32'd1234, 32'd5678));
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (valid32) pulses++;
    end
    start32 = 1'b0;
    chk("held_pulses", 64'(pulses), 64'd1);
    repeat (2) @(negedge clock);

    // Second request during RUN is ignored
    prev = prodt32;
    issue32(1'b1, 32'hDEAD_BEEF, 32'h0000_1234);
    repeat (4) @(negedge clock);
    start32 = 1'b1; sm32 = 1'b0; a32 = 32'h1111_1111; b32 = 32'h2222_2222;
    @(negedge clock);
    start32 = 1'b0;
    chk("prodt_held_run", prodt32, prev);
    wait_v32(n);
    repeat (3) @(negedge clock);
    chk("prodt_hold", prodt32, ref32(1'b1, 32'hDEAD_BEEF, 32'h0000_1234));
    chk("no_retrigger_busy", {63'b0, busy32}, 64'd0);

    // Reset 10 cycles into RUN
    issue32(1'b0, 32'hCAFE_F00D, 32'h0BAD_BEEF);
    repeat (10) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("rst_run_prodt", prodt32, 64'd0);
    chk("rst_run_busy", {63'b0, busy32}, 64'd0);
    exp_q32.delete();
    @(negedge clock);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (valid32) pulses++;
    end
    chk("rst_no_valid", 64'(pulses), 64'd0);
    issue32(1'b1, 32'h0000_0007, 32'hFFFF_FFF9);
    wait_v32(n);
    chk("after_rst_prod", prodt32, 64'hFFFF_FFFF_FFFF_FFCF);

    // Request in the DONE cycle
    issue32(1'b0, 32'h0001_0000, 32'h0000_0010);
    wait_v32(n);
    issue32(1'b1, 32'h8000_0000, 32'h7FFF_FFFF);
    wait_v32(n);
    chk("done_req_latency", 64'(n), 64'(ITER32));
    repeat (2) @(negedge clock);

    // Random phase, both widths in parallel
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          issue32(1'($urandom_range(0, 1)), rnd32(), rnd32());
          wait_v32(n);
          if ($urandom_range(0, 3) == 0) @(negedge clock);
        end
      end
      begin
        for (int i = 0; i < 1000; i++) begin
          logic s;
          logic [7:0] x, y;
          s = 1'($urandom_range(0, 1));
          x = 8'($urandom());
          y = 8'($urandom());
          start8 = 1'b1; sm8 = s; a8 = x; b8 = y;
          exp_q8.push_back(ref8(s, x, y));
          @(negedge clock);
          start8 = 1'b0;
          wait_v8();
          if ($urandom_range(0, 3) == 0) @(negedge clock);
        end
      end
    join
    repeat (3) @(negedge clock);
    chk("sb32_empty", 64'(exp_q32.size()), 64'd0);
    chk("sb8_empty", 64'(exp_q8.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
